// File: rtl/serial_capture_8.sv
// serial_capture_8: receiving end of a bit-serial shift interface.
// Samples Din on every cycle that Shift_En is high and assembles a WIDTH-bit
// frame. It presents the completed word on Data_Out with a Valid/Ack handshake,
// and flags truncated frames (Frame_Err) and bits that arrive while a word is
// still pending (Overrun).
//
// Optional build macro: SERIAL_CAPTURE_PARITY_EN
//   When defined, a frame is WIDTH data bits followed by one even-parity bit.
//   The parity bit is not stored, and the Parity_Err output is added.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Shift_En   in   bit strobe from the sender
//   Din        in   serial data bit
//   Ack        in   consumer has taken Data_Out (honoured only in DONE)
//   Data_Out   out  last completed word
//   Valid      out  word available (DONE)
//   Busy       out  frame in progress (RECV)
//   Bit_Count  out  bits sampled in the current frame
//   Frame_Err  out  one-cycle pulse when Shift_En drops mid-frame
//   Overrun    out  sticky flag for Shift_En seen in DONE; cleared by Ack
//   Parity_Err out  parity mismatch for the delivered word (parity build only)
module serial_capture_8 #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Shift_En,
  input  logic                         Din,
  input  logic                         Ack,
  output logic [WIDTH-1:0]             Data_Out,
  output logic                         Valid,
  output logic                         Busy,
  output logic [$clog2(WIDTH+2)-1:0]   Bit_Count,
  output logic                         Frame_Err,
  output logic                         Overrun
`ifdef SERIAL_CAPTURE_PARITY_EN
  ,
  output logic                         Parity_Err
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
`ifdef SERIAL_CAPTURE_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
`ifdef SERIAL_CAPTURE_PARITY_EN
  logic               parity_err_q, parity_err_d;
`endif

  logic [WIDTH-1:0]   shifted_c;
  logic               last_bit_c;

  // Shift register contents with Din appended; the bit order sets which end the first bit reaches.
  assign shifted_c  = MSB_FIRST ? {shreg_q[WIDTH-2:0], Din} : {Din, shreg_q[WIDTH-1:1]};
  // The sample taken in this cycle is the final bit of the frame.
  assign last_bit_c = (bit_count_q == CNT_W'(FRAME_LEN - 1));

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    data_out_d  = data_out_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    bit_count_d = bit_count_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef SERIAL_CAPTURE_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (Shift_En) begin
          shreg_d     = shifted_c;
          bit_count_d = CNT_W'(1);
          busy_d      = 1'b1;
          state_d     = RECV;
        end
      end

      RECV: begin
        if (Shift_En) begin
          if (last_bit_c) begin
`ifdef SERIAL_CAPTURE_PARITY_EN
            // Din is the parity bit: it is checked against the data but not stored.
            data_out_d   = shreg_q;
            parity_err_d = (^shreg_q) ^ Din;
`else
            shreg_d    = shifted_c;
            data_out_d = shifted_c;
`endif
            valid_d     = 1'b1;
            busy_d      = 1'b0;
            bit_count_d = '0;
            state_d     = DONE;
          end else begin
            shreg_d     = shifted_c;
            bit_count_d = bit_count_q + CNT_W'(1);
          end
        end else begin
          // Truncated frame: discard the partial word and leave Data_Out untouched.
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          bit_count_d = '0;
          state_d     = IDLE;
        end
      end

      DONE: begin
        if (Ack) begin
          valid_d   = 1'b0;
          overrun_d = 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
          parity_err_d = 1'b0;
`endif
          state_d   = IDLE;
        end
        // Assigned after the Ack clear so a simultaneous overrun wins.
        if (Shift_En) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      bit_count_q <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      bit_count_q <= bit_count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_CAPTURE_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign Data_Out  = data_out_q;
  assign Valid     = valid_q;
  assign Busy      = busy_q;
  assign Bit_Count = bit_count_q;
  assign Frame_Err = frame_err_q;
  assign Overrun   = overrun_q;
`ifdef SERIAL_CAPTURE_PARITY_EN
  assign Parity_Err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_capture_8.sv
// Testbench for serial_capture_8. It drives one MSB-first and one LSB-first
// instance with the same serial stream. Expected words are queued as frames are
// driven and are compared when Valid rises.
module tb_serial_capture_8;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
`ifdef SERIAL_CAPTURE_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif

  typedef struct packed {
    logic [7:0] msb_word;
    logic [7:0] lsb_word;
    logic       par_err;
  } exp_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic shift_en = 1'b0;
  logic din      = 1'b0;
  logic ack      = 1'b0;

  logic [WIDTH-1:0] m_data, l_data;
  logic             m_valid, l_valid, m_busy, l_busy, m_ferr, l_ferr, m_ovr, l_ovr;
  logic [CNT_W-1:0] m_cnt, l_cnt;
`ifdef SERIAL_CAPTURE_PARITY_EN
  logic             m_perr, l_perr;
`endif

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;

  serial_capture_8 #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .Clk(clk), .Reset_n(rst_n), .Shift_En(shift_en), .Din(din), .Ack(ack),
    .Data_Out(m_data), .Valid(m_valid), .Busy(m_busy), .Bit_Count(m_cnt),
    .Frame_Err(m_ferr), .Overrun(m_ovr)
`ifdef SERIAL_CAPTURE_PARITY_EN
    , .Parity_Err(m_perr)
`endif
  );

  serial_capture_8 #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(clk), .Reset_n(rst_n), .Shift_En(shift_en), .Din(din), .Ack(ack),
    .Data_Out(l_data), .Valid(l_valid), .Busy(l_busy), .Bit_Count(l_cnt),
    .Frame_Err(l_ferr), .Overrun(l_ovr)
`ifdef SERIAL_CAPTURE_PARITY_EN
    , .Parity_Err(l_perr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] reverse8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Serial bit k of a frame: data MSB first, then the parity bit.
  function automatic logic frame_bit(input logic [7:0] w, input logic par, input int k);
    logic [7:0] t;
    t = w;
    if (k < 8) return t[7-k];
    return par;
  endfunction

  // Drive all frame bits; Shift_En is left high after the last one.
  task automatic drive_frame(input logic [7:0] w, input logic par, input bit push);
    exp_t e;
    if (push) begin
      e.msb_word = w;
      e.lsb_word = reverse8(w);
      e.par_err  = (^w) ^ par;
      sb_q.push_back(e);
    end
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("cnt_mid", 32'(m_cnt), 32'(k));
        check("busy_mid", 32'(m_busy), 32'd1);
      end
      shift_en = 1'b1;
      din      = frame_bit(w, par, k);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    shift_en = 1'b0;
    din      = 1'b0;
    check("done_valid", 32'(m_valid), 32'd1);
    check("done_busy", 32'(m_busy), 32'd0);
    check("done_cnt", 32'(m_cnt), 32'd0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_valid", 32'(m_valid), 32'd0);
  endtask

  // Scoreboard: compare the completed word whenever Valid rises.
  always @(negedge clk) begin
    exp_t e;
    if (m_valid && !valid_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_data_msb", 32'(m_data), 32'(e.msb_word));
        check("sb_data_lsb", 32'(l_data), 32'(e.lsb_word));
        check("sb_valid_lsb", 32'(l_valid), 32'd1);
`ifdef SERIAL_CAPTURE_PARITY_EN
        check("sb_par_err", 32'(m_perr), 32'(e.par_err));
`endif
      end
    end
    valid_prev = m_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_cnt", 32'(m_cnt), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_ferr", 32'(m_ferr), 32'd0);
    check("rst_ovr", 32'(m_ovr), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset part-way through a frame.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      shift_en = 1'b1;
      din      = k[0];
    end
    @(negedge clk);
    check("pre_rst_cnt", 32'(m_cnt), 32'd4);
    check("pre_rst_busy", 32'(m_busy), 32'd1);
    shift_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(m_busy), 32'd0);
    check("async_rst_cnt", 32'(m_cnt), 32'd0);
    check("async_rst_valid", 32'(m_valid), 32'd0);
    check("async_rst_ferr", 32'(m_ferr), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ferr", 32'(m_ferr), 32'd0);
    drive_frame(8'hA5, ^8'hA5, 1'b1);
    end_frame();
    do_ack();

    // Known word: bits 1,0,1,1,0,0,1,0.
    drive_frame(8'hB2, ^8'hB2, 1'b1);
    end_frame();
    check("b2_msb", 32'(m_data), 32'h0000_00B2);
    check("b2_lsb", 32'(l_data), 32'h0000_004D);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("valid_hold", 32'(m_valid), 32'd1);
    end
    do_ack();
    check("ack_data_hold", 32'(m_data), 32'h0000_00B2);

    // Truncated frame after 5 bits.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      shift_en = 1'b1;
      din      = frame_bit(8'h5A, 1'b0, k);
    end
    @(negedge clk);
    shift_en = 1'b0;
    @(negedge clk);
    check("trunc_ferr", 32'(m_ferr), 32'd1);
    check("trunc_valid", 32'(m_valid), 32'd0);
    check("trunc_busy", 32'(m_busy), 32'd0);
    check("trunc_cnt", 32'(m_cnt), 32'd0);
    check("trunc_data", 32'(m_data), 32'h0000_00B2);
    check("trunc_data_lsb", 32'(l_data), 32'h0000_004D);
    @(negedge clk);
    check("trunc_ferr_pulse", 32'(m_ferr), 32'd0);

    // Ack in IDLE has no effect.
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("idle_ack_valid", 32'(m_valid), 32'd0);
    check("idle_ack_busy", 32'(m_busy), 32'd0);

    // Overrun: Shift_En continues past the end of the frame.
    drive_frame(8'h3C, ^8'h3C, 1'b1);
    @(negedge clk);
    shift_en = 1'b1;
    din      = 1'b1;
    check("ovr_first_done", 32'(m_ovr), 32'd0);
    @(negedge clk);
    check("ovr_set", 32'(m_ovr), 32'd1);
    check("ovr_valid", 32'(m_valid), 32'd1);
    check("ovr_cnt", 32'(m_cnt), 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack      = 1'b0;
    shift_en = 1'b0;
    check("ovr_set_wins", 32'(m_ovr), 32'd1);
    check("ovr_ack_valid", 32'(m_valid), 32'd0);
    check("ovr_ack_busy", 32'(m_busy), 32'd0);
    check("ovr_data", 32'(m_data), 32'h0000_003C);
    drive_frame(8'h81, ^8'h81, 1'b1);
    end_frame();
    check("ovr_sticky", 32'(m_ovr), 32'd1);
    do_ack();
    check("ovr_cleared", 32'(m_ovr), 32'd0);

`ifdef SERIAL_CAPTURE_PARITY_EN
    drive_frame(8'hB2, 1'b1, 1'b1);
    end_frame();
    check("par_bad", 32'(m_perr), 32'd1);
    check("par_bad_data", 32'(m_data), 32'h0000_00B2);
    do_ack();
    check("par_ack_clr", 32'(m_perr), 32'd0);
    drive_frame(8'hB2, 1'b0, 1'b1);
    end_frame();
    check("par_good", 32'(m_perr), 32'd0);
    do_ack();
`endif

    // A few arbitrary words.
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom_range(0, 255));
      drive_frame(w, ^w, 1'b1);
      end_frame();
      do_ack();
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
